// File: rtl/pipe_pkg.sv
// Shared opcode constants, FSM state type and helpers for the pipeline
// hazard logic.
package pipe_pkg;

   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_LW  = 6'b100011;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      BR_WAIT = 2'd1
   } hazard_state_t;

   function automatic logic is_ctl_op(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Detects a load in EX whose destination is read by the instruction in ID.
module load_use_detect
   import pipe_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   output logic       load_use
);

   // $zero is never a real dependency even if a load targets it.
   assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory hold, load-use and
// control-transfer arbitration plus a saturating stall-cycle counter.
module hazard_controller
   import pipe_pkg::*;
#(
   parameter int unsigned BRANCH_SLOTS = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             mem_hold,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             branch_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [2:0] LAST_SLOT = 3'(BRANCH_SLOTS);

   hazard_state_t    state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             load_use;

   load_use_detect u_load_use_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .load_use    (load_use)
   );

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      branch_busy = (state_q == BR_WAIT);
      state_d     = state_q;
      cnt_d       = cnt_q;
      if (rst) begin
         branch_busy = 1'b0;
      end else if (mem_hold) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else begin
         case (state_q)
            BR_WAIT: begin
               // IF/ID holds a flushed NOP, so the ID opcode is irrelevant here.
               ifid_flush = 1'b1;
               if (cnt_q == LAST_SLOT) begin
                  state_d = RUN;
                  cnt_d   = 3'd0;
               end else begin
                  pc_write = 1'b0;
                  cnt_d    = cnt_q + 3'd1;
               end
            end
            default: begin
               if (load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end else if (is_ctl_op(id_opcode)) begin
                  pc_write   = 1'b0;
                  ifid_flush = 1'b1;
                  state_d    = BR_WAIT;
                  cnt_d      = 3'd1;
               end
            end
         endcase
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (!pc_write && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized check of hazard_controller against a cycle-level
// reference model; a second instance with a 4-bit counter covers saturation.
module tb_hazard_controller;
   import pipe_pkg::*;

   localparam int unsigned SLOTS = 2;

   logic        clk;
   logic        rst;
   logic [5:0]  id_opcode;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_mem_read;
   logic [4:0]  ex_rt;
   logic        mem_hold;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble, branch_busy;
   logic [15:0] stall_cycles;
   logic        pc_write4, ifid_write4, ifid_flush4, idex_bubble4, branch_busy4;
   logic [3:0]  stall_cycles4;

   int checks   = 0;
   int failures = 0;

   // Reference model: position within the branch wait (0 = none) and total stalls.
   int     br_age;
   longint stalls;
   bit     mdl_valid;

   hazard_controller #(.BRANCH_SLOTS(SLOTS), .CNT_W(16)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .id_opcode    (id_opcode),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_mem_read  (ex_mem_read),
      .ex_rt        (ex_rt),
      .mem_hold     (mem_hold),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble),
      .branch_busy  (branch_busy),
      .stall_cycles (stall_cycles)
   );

   hazard_controller #(.BRANCH_SLOTS(SLOTS), .CNT_W(4)) u_dut4 (
      .clk          (clk),
      .rst          (rst),
      .id_opcode    (id_opcode),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_mem_read  (ex_mem_read),
      .ex_rt        (ex_rt),
      .mem_hold     (mem_hold),
      .pc_write     (pc_write4),
      .ifid_write   (ifid_write4),
      .ifid_flush   (ifid_flush4),
      .idex_bubble  (idex_bubble4),
      .branch_busy  (branch_busy4),
      .stall_cycles (stall_cycles4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_in(input bit r, input bit h, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                         input bit emr, input logic [4:0] ert);
      rst = r; mem_hold = h; id_opcode = op; id_rs = rs; id_rt = rt;
      id_uses_rt = urt; ex_mem_read = emr; ex_rt = ert;
   endtask

   // One pipeline cycle: check Mealy outputs, clock, then advance the model.
   task automatic cyc();
      bit e_pc, e_ifw, e_fl, e_bub, e_busy, lu, ctl;
      longint e16, e4;
      #2;
      lu  = ex_mem_read && (ex_rt != 0) &&
            ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      ctl = (id_opcode == 6'd4) || (id_opcode == 6'd5) || (id_opcode == 6'd2);
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_busy = (br_age != 0);
      if (rst) e_busy = 0;
      else if (mem_hold) begin e_pc = 0; e_ifw = 0; end
      else if (br_age != 0) begin e_fl = 1; e_pc = (br_age == SLOTS); end
      else if (lu) begin e_pc = 0; e_ifw = 0; e_bub = 1; end
      else if (ctl) begin e_pc = 0; e_fl = 1; end
      chk("pc_write", 32'(pc_write), 32'(e_pc));
      chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
      if (e_ifw) chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
      chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
      chk("branch_busy", 32'(branch_busy), 32'(e_busy));
      if (mdl_valid) begin
         e16 = (stalls > 65535) ? 65535 : stalls;
         e4  = (stalls > 15) ? 15 : stalls;
         chk("stall_cycles", 32'(stall_cycles), 32'(e16));
         chk("stall_cycles4", 32'(stall_cycles4), 32'(e4));
      end
      @(posedge clk);
      if (rst) begin
         br_age = 0; stalls = 0; mdl_valid = 1;
      end else if (!e_pc) begin
         stalls++;
      end
      if (!rst && !mem_hold) begin
         if (br_age != 0) br_age = (br_age == SLOTS) ? 0 : br_age + 1;
         else if (ctl && !lu) br_age = 1;
      end
      #1;
   endtask

   initial begin
      br_age = 0; stalls = 0; mdl_valid = 0;
      set_in(1, 0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0);
      // Reset held for two cycles.
      cyc(); cyc();
      set_in(0, 0, 6'd0, 5'd1, 5'd2, 1, 0, 5'd0);
      cyc();
      // Load-use on rs.
      set_in(0, 0, 6'd0, 5'd8, 5'd3, 1, 1, 5'd8); cyc();
      set_in(0, 0, 6'd0, 5'd8, 5'd3, 1, 0, 5'd8); cyc();
      chk("lu_stalls", 32'(stall_cycles), 32'd1);
      // beq with two slots.
      set_in(0, 0, OP_BEQ, 5'd1, 5'd2, 1, 0, 5'd0); cyc();
      set_in(0, 0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0);
      repeat (3) cyc();
      chk("beq_stalls", 32'(stall_cycles), 32'd3);
      // Load-use on a bne rt operand, then the branch is accepted.
      set_in(0, 0, OP_BNE, 5'd1, 5'd9, 1, 1, 5'd9); cyc();
      set_in(0, 0, OP_BNE, 5'd1, 5'd9, 1, 0, 5'd9); cyc();
      set_in(0, 0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0);
      repeat (3) cyc();
      // Memory hold in the middle of a branch wait.
      set_in(0, 0, OP_J, 5'd0, 5'd0, 0, 0, 5'd0); cyc();
      set_in(0, 1, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0);
      repeat (3) cyc();
      set_in(0, 0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0);
      repeat (3) cyc();
      // Reset during a branch wait drops the branch.
      set_in(0, 0, OP_BEQ, 5'd4, 5'd5, 1, 0, 5'd0); cyc();
      set_in(1, 0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0); cyc();
      set_in(0, 0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0); cyc();
      // Long hold drives the narrow counter into saturation.
      set_in(0, 1, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0);
      repeat (20) cyc();
      chk("sat4", 32'(stall_cycles4), 32'd15);
      chk("sat16", 32'(stall_cycles), 32'd20);
      // Randomized traffic with small register ranges to provoke hazards.
      for (int i = 0; i < 600; i++) begin
         logic [5:0] op;
         case ($urandom_range(0, 5))
            0: op = OP_BEQ;
            1: op = OP_BNE;
            2: op = OP_J;
            3: op = OP_LW;
            4: op = 6'd0;
            default: op = 6'($urandom);
         endcase
         set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), op,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)));
         cyc();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
